// File: rtl/sysbus_mem_responder_if.sv
// sysbus_mem_responder_if
//   Request/response bus between an initiator (master) and the memory
//   responder (slave).
//   reqcyc  : initiator has a request or write-data beat valid
//   req     : request address (request phase) / write data (data phase)
//   reqtag  : {dir (1=READ), type[3:0], id[7:0]}
//   reqack  : one-cycle pulse, request phase accepted
//   respcyc : read response beat valid
//   resp    : read response data beat
//   resptag : tag echoed from the accepted request
//   respack : initiator consumed the current beat
interface sysbus_mem_responder_if;
  logic        reqcyc;
  logic [63:0] req;
  logic [12:0] reqtag;
  logic        reqack;
  logic        respcyc;
  logic [63:0] resp;
  logic [12:0] resptag;
  logic        respack;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );
endinterface

// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder
//   Line-based memory responder with a 64-bit backing store. A request
//   carries a line address (req[63:6]); a line is 8 consecutive 64-bit words.
//   Writes take 8 data beats on req; reads return 8 beats on resp after a
//   fixed LATENCY measured from the reqack cycle.
//   Parameters: LATENCY   (1..255) cycles from reqack to first read beat
//               MEM_WORDS (power of two, >= 16) store depth in words
//   Ports: clk   - rising-edge clock
//          reset - synchronous active-high reset (store contents kept)
//          bus   - slave side of sysbus_mem_responder_if
//
// state | meaning
// IDLE  | waiting for a request phase
// WDATA | collecting 8 write-data beats (reqcyc=0 cycles are stalls)
// WAIT  | read latency down-counter running
// RESP  | presenting read beats, advancing on respack
module sysbus_mem_responder #(
  parameter int LATENCY   = 4,
  parameter int MEM_WORDS = 1024
) (
  input logic                    clk,
  input logic                    reset,
  sysbus_mem_responder_if.slave  bus
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int LW = AW - 3;
  localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WDATA = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]    state;
  logic [LW-1:0] line_q;
  logic [12:0]   tag_q;
  logic [2:0]    beat_q;
  logic [7:0]    lat_q;
  logic          reqack_q;
  logic          respcyc_q;
  logic [63:0]   resp_q;

  logic [63:0] mem [MEM_WORDS];

  // Lines are 8-word aligned, so the beat index fills the low address bits
  // and wrap modulo MEM_WORDS is simply truncation of the line address.
  logic [AW-1:0] cur_idx;
  logic [AW-1:0] nxt_idx;
  logic [AW-1:0] first_idx;
  logic          mem_we;

  assign cur_idx   = {line_q, beat_q};
  assign nxt_idx   = {line_q, beat_q + 3'd1};
  assign first_idx = {line_q, 3'd0};
  assign mem_we    = !reset && (state == WDATA) && bus.reqcyc;

  // No reset on the store: contents survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[cur_idx] <= bus.req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      line_q    <= '0;
      tag_q     <= '0;
      beat_q    <= '0;
      lat_q     <= '0;
      reqack_q  <= 1'b0;
      respcyc_q <= 1'b0;
      resp_q    <= '0;
    end else begin
      reqack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.reqcyc) begin
            line_q   <= bus.req[AW+2:6];
            tag_q    <= bus.reqtag;
            beat_q   <= 3'd0;
            reqack_q <= 1'b1;
            if (bus.reqtag[12]) begin
              lat_q <= LAT_LOAD;
              state <= WAIT;
            end else begin
              state <= WDATA;
            end
          end
        end
        WDATA: begin
          if (bus.reqcyc) begin
            beat_q <= beat_q + 3'd1;
            if (beat_q == 3'd7) begin
              state <= IDLE;
            end
          end
        end
        WAIT: begin
          if (lat_q == 8'd0) begin
            state     <= RESP;
            respcyc_q <= 1'b1;
            resp_q    <= mem[first_idx];
          end else begin
            lat_q <= lat_q - 8'd1;
          end
        end
        RESP: begin
          if (bus.respack) begin
            if (beat_q == 3'd7) begin
              state     <= IDLE;
              respcyc_q <= 1'b0;
              resp_q    <= '0;
              beat_q    <= 3'd0;
            end else begin
              beat_q <= beat_q + 3'd1;
              resp_q <= mem[nxt_idx];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.reqack  = reqack_q;
  assign bus.respcyc = respcyc_q;
  assign bus.resp    = resp_q;
  assign bus.resptag = tag_q;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
module tb_sysbus_mem_responder;
  localparam int LAT = 4;
  localparam int MW  = 1024;

  logic clk = 1'b0;
  logic reset;
  logic reset1;
  always #5 clk = ~clk;

  sysbus_mem_responder_if bus ();
  sysbus_mem_responder_if bus1 ();

  sysbus_mem_responder #(.LATENCY(LAT), .MEM_WORDS(MW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  sysbus_mem_responder #(.LATENCY(1), .MEM_WORDS(MW)) dut1 (
    .clk(clk), .reset(reset1), .bus(bus1)
  );

  typedef struct {
    logic [63:0] data;
    logic [12:0] tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] ref_mem [MW];
  logic [63:0] wd [8];
  logic [63:0] written[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ack_cyc = 0;
  int ack_count = 0;
  int ack_mode = 0;
  int pat_i = 0;
  bit mon_on = 0;
  bit rd_pending = 0;
  bit wait_first = 0;
  bit chk_rst = 0;
  bit prev_reqack = 0;
  bit prev_respcyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word index of beat i of the line addressed by a: 8-word lines, wrap mod MW.
  function automatic int widx(input logic [63:0] a, input int i);
    logic [63:0] w;
    w = (((a >> 6) * 64'd8) + 64'(i)) % 64'(MW);
    return int'(w);
  endfunction

  // respack pattern: 0 = always 1, 1 = 1,0,0 repeating, 2 = random
  always @(posedge clk) begin
    #1;
    case (ack_mode)
      0:       bus.respack = 1'b1;
      1:       bus.respack = ((pat_i % 3) == 0);
      default: bus.respack = 1'($urandom_range(0, 1));
    endcase
    pat_i++;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (mon_on) begin
      if (chk_rst) begin
        check("rst_respcyc", 64'(bus.respcyc), 64'd0);
        check("rst_resp", bus.resp, 64'd0);
        check("rst_resptag", 64'(bus.resptag), 64'd0);
        check("rst_reqack", 64'(bus.reqack), 64'd0);
        chk_rst = 0;
      end
      if (bus.reqack) begin
        check("ack_after_idle", {62'd0, prev_reqack, prev_respcyc}, 64'd0);
        ack_count++;
        if (rd_pending) begin
          ack_cyc = cyc;
          wait_first = 1;
          rd_pending = 0;
        end
      end
      if (bus.respcyc) begin
        if (wait_first) begin
          check("first_beat_latency", 64'(cyc - ack_cyc), 64'(LAT));
          wait_first = 0;
        end
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got resp %0h, expected no beat", bus.resp);
        end else begin
          check("resp", bus.resp, exp_q[0].data);
          check("resptag", 64'(bus.resptag), 64'(exp_q[0].tag));
          if (bus.respack && !reset) void'(exp_q.pop_front());
        end
      end else begin
        check("resp_zero_idle", bus.resp, 64'd0);
      end
      if (reset) begin
        exp_q.delete();
        chk_rst = 1;
        wait_first = 0;
        rd_pending = 0;
      end
      prev_reqack = bus.reqack;
      prev_respcyc = bus.respcyc;
    end
  end

  task automatic wait_ack(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.reqack && n < 50);
    if (!bus.reqack) timeout(name);
  endtask

  task automatic wait_drain(input string name, input int left);
    int n = 0;
    while (exp_q.size() > left && n < 400) begin
      tick();
      n++;
    end
    if (exp_q.size() > left) begin
      timeout(name);
      exp_q.delete();
    end
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [12:0] tag, input bit stalls);
    bus.reqcyc = 1'b1;
    bus.req = addr;
    bus.reqtag = tag;
    wait_ack("wr_ack");
    for (int i = 0; i < 8; i++) begin
      if (stalls) begin
        repeat ($urandom_range(0, 2)) begin
          bus.reqcyc = 1'b0;
          bus.req = 64'hDEAD_BEEF_0BAD_F00D;
          tick();
        end
      end
      bus.reqcyc = 1'b1;
      bus.req = wd[i];
      ref_mem[widx(addr, i)] = wd[i];
      tick();
    end
    bus.reqcyc = 1'b0;
    written.push_back(addr);
  endtask

  task automatic push_line(input logic [63:0] addr, input logic [12:0] tag);
    for (int i = 0; i < 8; i++) exp_q.push_back('{data: ref_mem[widx(addr, i)], tag: tag});
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [12:0] tag, input int mode, input bit hold);
    int acks0;
    int n;
    ack_mode = mode;
    acks0 = ack_count;
    push_line(addr, tag);
    if (hold) push_line(addr, tag);
    rd_pending = 1;
    bus.reqcyc = 1'b1;
    bus.req = addr;
    bus.reqtag = tag;
    wait_ack("rd_ack");
    if (!hold) begin
      bus.reqcyc = 1'b0;
      bus.req = 64'h0123_4567_89AB_CDEF;
    end else begin
      wait_drain("hold_first_read", 8);
      check("hold_single_ack", 64'(ack_count - acks0), 64'd1);
      rd_pending = 1;
      n = 0;
      while (ack_count < acks0 + 2 && n < 50) begin
        tick();
        n++;
      end
      if (ack_count < acks0 + 2) timeout("hold_second_ack");
      bus.reqcyc = 1'b0;
    end
    wait_drain("rd_drain", 0);
    if (hold) check("hold_total_acks", 64'(ack_count - acks0), 64'd2);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8; i++) wd[i] = {32'($urandom), 32'($urandom)};
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [63:0] a;
    int n;

    reset = 1'b1;
    reset1 = 1'b1;
    bus.reqcyc = 1'b0;
    bus.req = '0;
    bus.reqtag = '0;
    bus1.reqcyc = 1'b0;
    bus1.req = '0;
    bus1.reqtag = '0;
    bus1.respack = 1'b1;
    repeat (3) tick();
    check("reset_respcyc", 64'(bus.respcyc), 64'd0);
    check("reset_resp", bus.resp, 64'd0);
    check("reset_resptag", 64'(bus.resptag), 64'd0);
    check("reset_reqack", 64'(bus.reqack), 64'd0);
    reset = 1'b0;
    reset1 = 1'b0;
    tick();
    mon_on = 1;

    // Directed write 0x40, read back via unaligned 0x47
    for (int i = 0; i < 8; i++) wd[i] = 64'(i + 1) * 64'h11;
    do_write(64'h40, 13'h0100, 1'b0);
    do_read(64'h47, 13'h11A5, 0, 1'b0);

    // respack 1,0,0 pattern: stalls must hold resp/resptag
    do_read(64'h40, 13'h10AA, 1, 1'b0);

    // reqcyc held high throughout a read
    do_read(64'h40, 13'h1033, 0, 1'b1);

    // Aliasing at the top of the store and wrap to word 0
    fill_random();
    do_write(64'h1FC0 + 64'h2000, 13'h0201, 1'b1);
    do_read(64'h1FC0, 13'h1202, 2, 1'b0);
    fill_random();
    do_write(64'h2000, 13'h0203, 1'b0);
    do_read(64'h0, 13'h1204, 0, 1'b0);
    do_read(64'h3FC0, 13'h1205, 1, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 12; t++) begin
      fill_random();
      a = {32'($urandom), 32'($urandom)};
      do_write(a, {1'b0, 12'($urandom)}, 1'b1);
      a = written[$urandom_range(0, written.size() - 1)];
      a[5:0] = 6'($urandom);
      do_read(a, {1'b1, 12'($urandom)}, int'($urandom_range(0, 2)), 1'b0);
    end

    // Reset while beat 3 of a read is presented
    ack_mode = 0;
    push_line(64'h1FC0, 13'h1777);
    rd_pending = 1;
    bus.reqcyc = 1'b1;
    bus.req = 64'h1FC0;
    bus.reqtag = 13'h1777;
    wait_ack("rst_rd_ack");
    bus.reqcyc = 1'b0;
    wait_drain("rst_rd_beat3", 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_queue", 64'(exp_q.size()), 64'd0);
    do_read(64'h1FC0, 13'h1778, 0, 1'b0);
    do_read(written[0], 13'h1779, 2, 1'b0);

    // LATENCY=1 instance: first beat the cycle right after reqack
    bus1.reqcyc = 1'b1;
    bus1.req = 64'h0;
    bus1.reqtag = 13'h0042;
    tick();
    check("lat1_wr_ack", 64'(bus1.reqack), 64'd1);
    for (int i = 0; i < 8; i++) begin
      bus1.req = 64'hA0 + 64'(i);
      tick();
    end
    bus1.reqcyc = 1'b1;
    bus1.req = 64'h5;
    bus1.reqtag = 13'h1042;
    tick();
    check("lat1_rd_ack", 64'(bus1.reqack), 64'd1);
    check("lat1_no_beat_in_ack_cycle", 64'(bus1.respcyc), 64'd0);
    bus1.reqcyc = 1'b0;
    tick();
    check("lat1_first_respcyc", 64'(bus1.respcyc), 64'd1);
    for (int i = 0; i < 8; i++) begin
      check("lat1_resp", bus1.resp, 64'hA0 + 64'(i));
      check("lat1_resptag", 64'(bus1.resptag), 64'h1042);
      tick();
    end
    check("lat1_done", 64'(bus1.respcyc), 64'd0);

    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      tick();
      n++;
    end
    tick();
    mon_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
